// File: rtl/rename_unit.sv
// 2-wide register rename stage: RAT lookup, circular free-list allocation and busy tracking.
// Results are registered and held while the issue queue stalls.
module rename_unit #(
    parameter int unsigned PHYS_REGS            = 64,
    parameter int unsigned PHYS_REGS_ADDR_WIDTH = $clog2(PHYS_REGS),
    parameter int unsigned FREE_LIST_SIZE       = PHYS_REGS - 32,
    parameter int unsigned DISPATCH_WIDTH       = 2
) (
    input  logic                                                clk,
    input  logic                                                rst,
    input  logic [DISPATCH_WIDTH-1:0]                           in_valid,
    input  logic [DISPATCH_WIDTH-1:0][4:0]                      in_rs1,
    input  logic [DISPATCH_WIDTH-1:0][4:0]                      in_rs2,
    input  logic [DISPATCH_WIDTH-1:0][4:0]                      in_rd,
    input  logic [DISPATCH_WIDTH-1:0]                           in_rd_we,
    output logic                                                in_ready,
    output logic [DISPATCH_WIDTH-1:0]                           out_valid,
    output logic [DISPATCH_WIDTH-1:0][PHYS_REGS_ADDR_WIDTH-1:0] out_phys_rs1,
    output logic [DISPATCH_WIDTH-1:0][PHYS_REGS_ADDR_WIDTH-1:0] out_phys_rs2,
    output logic [DISPATCH_WIDTH-1:0][PHYS_REGS_ADDR_WIDTH-1:0] out_phys_rd,
    output logic [DISPATCH_WIDTH-1:0][PHYS_REGS_ADDR_WIDTH-1:0] out_old_phys_rd,
    output logic [DISPATCH_WIDTH-1:0]                           out_rs1_ready,
    output logic [DISPATCH_WIDTH-1:0]                           out_rs2_ready,
    input  logic                                                stall,
    input  logic [DISPATCH_WIDTH-1:0]                           wb_valid,
    input  logic [DISPATCH_WIDTH-1:0][PHYS_REGS_ADDR_WIDTH-1:0] wb_phys_rd,
    input  logic [DISPATCH_WIDTH-1:0]                           commit_valid,
    input  logic [DISPATCH_WIDTH-1:0][PHYS_REGS_ADDR_WIDTH-1:0] commit_old_phys_rd
);

    localparam int unsigned PW = PHYS_REGS_ADDR_WIDTH;
    localparam int unsigned FW = $clog2(FREE_LIST_SIZE);
    localparam int unsigned CW = $clog2(FREE_LIST_SIZE + 1);

    logic [PW-1:0]        rat       [32];
    logic [PW-1:0]        free_list [FREE_LIST_SIZE];
    logic [FW-1:0]        head;
    logic [FW-1:0]        tail;
    logic [CW-1:0]        free_count;
    logic [PHYS_REGS-1:0] busy;

    logic                 accept;
    logic [1:0]           need;
    logic [1:0]           pop_cnt;
    logic [1:0]           pop_eff;
    logic [1:0]           push_en;
    logic [1:0]           push_cnt;
    logic [FW-1:0]        head1;
    logic [FW-1:0]        head_nxt;
    logic [FW-1:0]        tail1;
    logic [FW-1:0]        tail_nxt;
    logic [1:0][PW-1:0]   alloc;
    logic [1:0][PW-1:0]   prd;
    logic [1:0][PW-1:0]   old_prd;
    logic [1:0][1:0][4:0] arch_src;
    logic [1:0][1:0][PW-1:0] src_phys;
    logic [1:0][1:0]      src_rdy;

    function automatic logic [FW-1:0] fl_inc(input logic [FW-1:0] p);
        return (32'(p) == FREE_LIST_SIZE - 1) ? '0 : p + FW'(1);
    endfunction

    assign in_ready = (free_count >= CW'(2)) && !((|out_valid) && stall);
    assign accept   = in_ready && (|in_valid);

    // Allocation, source lookup with intra-group and writeback bypass, free-list pointers
    always_comb begin
        need     = '0;
        alloc    = '0;
        prd      = '0;
        old_prd  = '0;
        arch_src = '0;
        src_phys = '0;
        src_rdy  = '0;
        push_en  = '0;

        for (int l = 0; l < 2; l++) begin
            need[l]        = in_valid[l] && in_rd_we[l] && (in_rd[l] != 5'd0);
            arch_src[l][0] = in_rs1[l];
            arch_src[l][1] = in_rs2[l];
            push_en[l]     = commit_valid[l] && (commit_old_phys_rd[l] != '0);
        end

        pop_cnt  = {1'b0, need[0]} + {1'b0, need[1]};
        pop_eff  = accept ? pop_cnt : 2'd0;
        push_cnt = {1'b0, push_en[0]} + {1'b0, push_en[1]};

        head1    = fl_inc(head);
        alloc[0] = free_list[head];
        alloc[1] = need[0] ? free_list[head1] : free_list[head];
        head_nxt = (pop_cnt == 2'd2) ? fl_inc(head1) : ((pop_cnt == 2'd1) ? head1 : head);

        tail1    = push_en[0] ? fl_inc(tail) : tail;
        tail_nxt = push_en[1] ? fl_inc(tail1) : tail1;

        for (int l = 0; l < 2; l++) begin
            for (int s = 0; s < 2; s++) begin
                if (arch_src[l][s] == 5'd0) begin
                    src_phys[l][s] = '0;
                    src_rdy[l][s]  = 1'b1;
                end else if (l == 1 && need[0] && arch_src[l][s] == in_rd[0]) begin
                    src_phys[l][s] = alloc[0];
                    src_rdy[l][s]  = 1'b0;
                end else begin
                    src_phys[l][s] = rat[arch_src[l][s]];
                    src_rdy[l][s]  = !busy[src_phys[l][s]]
                                   || (wb_valid[0] && wb_phys_rd[0] == src_phys[l][s])
                                   || (wb_valid[1] && wb_phys_rd[1] == src_phys[l][s]);
                end
            end
        end

        prd[0]     = need[0] ? alloc[0] : '0;
        prd[1]     = need[1] ? alloc[1] : '0;
        old_prd[0] = need[0] ? rat[in_rd[0]] : '0;
        // Same-rd pair: lane 1's stale mapping is lane 0's fresh allocation
        if (need[1]) begin
            old_prd[1] = (need[0] && in_rd[1] == in_rd[0]) ? alloc[0] : rat[in_rd[1]];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) rat[i] <= PW'(i);
            for (int i = 0; i < int'(FREE_LIST_SIZE); i++) free_list[i] <= PW'(32 + i);
            head            <= '0;
            tail            <= '0;
            free_count      <= CW'(FREE_LIST_SIZE);
            busy            <= '0;
            out_valid       <= '0;
            out_phys_rs1    <= '0;
            out_phys_rs2    <= '0;
            out_phys_rd     <= '0;
            out_old_phys_rd <= '0;
            out_rs1_ready   <= '0;
            out_rs2_ready   <= '0;
        end else begin
            assert (int'(free_count) + int'(push_cnt) - int'(pop_eff) <= int'(FREE_LIST_SIZE))
                else $error("rename_unit: free list overflow");

            if (accept) begin
                head <= head_nxt;
                if (need[0]) begin
                    rat[in_rd[0]]  <= alloc[0];
                    busy[alloc[0]] <= 1'b1;
                end
                if (need[1]) begin
                    rat[in_rd[1]]  <= alloc[1];
                    busy[alloc[1]] <= 1'b1;
                end
            end

            // Writeback clears come after allocation sets so they win
            for (int l = 0; l < 2; l++) begin
                if (wb_valid[l] && wb_phys_rd[l] != '0) busy[wb_phys_rd[l]] <= 1'b0;
            end

            if (push_en[0]) free_list[tail]  <= commit_old_phys_rd[0];
            if (push_en[1]) free_list[tail1] <= commit_old_phys_rd[1];
            tail       <= tail_nxt;
            free_count <= free_count + CW'(push_cnt) - CW'(pop_eff);

            if (!(stall && (|out_valid))) begin
                if (accept) begin
                    out_valid       <= in_valid;
                    for (int l = 0; l < 2; l++) begin
                        out_phys_rs1[l]  <= src_phys[l][0];
                        out_phys_rs2[l]  <= src_phys[l][1];
                        out_rs1_ready[l] <= src_rdy[l][0];
                        out_rs2_ready[l] <= src_rdy[l][1];
                    end
                    out_phys_rd     <= prd;
                    out_old_phys_rd <= old_prd;
                end else begin
                    out_valid <= '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_rename_unit.sv
// Scoreboard bench for rename_unit: expected rename results are queued at issue and
// compared when the registered result appears.
module tb_rename_unit;

    logic            clk;
    logic            rst;
    logic [1:0]      in_valid;
    logic [1:0][4:0] in_rs1;
    logic [1:0][4:0] in_rs2;
    logic [1:0][4:0] in_rd;
    logic [1:0]      in_rd_we;
    logic            in_ready;
    logic [1:0]      out_valid;
    logic [1:0][5:0] out_phys_rs1;
    logic [1:0][5:0] out_phys_rs2;
    logic [1:0][5:0] out_phys_rd;
    logic [1:0][5:0] out_old_phys_rd;
    logic [1:0]      out_rs1_ready;
    logic [1:0]      out_rs2_ready;
    logic            stall;
    logic [1:0]      wb_valid;
    logic [1:0][5:0] wb_phys_rd;
    logic [1:0]      commit_valid;
    logic [1:0][5:0] commit_old_phys_rd;

    int          checks = 0;
    int          fails  = 0;
    logic [53:0] exp_q[$];
    logic [53:0] got;
    logic [53:0] want;
    logic [53:0] held;

    rename_unit dut (
        .clk                (clk),
        .rst                (rst),
        .in_valid           (in_valid),
        .in_rs1             (in_rs1),
        .in_rs2             (in_rs2),
        .in_rd              (in_rd),
        .in_rd_we           (in_rd_we),
        .in_ready           (in_ready),
        .out_valid          (out_valid),
        .out_phys_rs1       (out_phys_rs1),
        .out_phys_rs2       (out_phys_rs2),
        .out_phys_rd        (out_phys_rd),
        .out_old_phys_rd    (out_old_phys_rd),
        .out_rs1_ready      (out_rs1_ready),
        .out_rs2_ready      (out_rs2_ready),
        .stall              (stall),
        .wb_valid           (wb_valid),
        .wb_phys_rd         (wb_phys_rd),
        .commit_valid       (commit_valid),
        .commit_old_phys_rd (commit_old_phys_rd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    function automatic logic [53:0] obs_vec();
        return {out_valid, out_phys_rs1, out_phys_rs2, out_phys_rd, out_old_phys_rd,
                out_rs1_ready, out_rs2_ready};
    endfunction

    function automatic logic [53:0] mk(input int v,
                                       input int a0, input int b0, input int d0, input int o0,
                                       input int r10, input int r20,
                                       input int a1, input int b1, input int d1, input int o1,
                                       input int r11, input int r21);
        return {2'(v), 6'(a1), 6'(a0), 6'(b1), 6'(b0), 6'(d1), 6'(d0), 6'(o1), 6'(o0),
                1'(r11), 1'(r10), 1'(r21), 1'(r20)};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_group(input int rs1_0, input int rs2_0, input int rd_0, input int we_0,
                             input int rs1_1, input int rs2_1, input int rd_1, input int we_1);
        in_valid    = 2'b11;
        in_rs1[0]   = 5'(rs1_0);
        in_rs2[0]   = 5'(rs2_0);
        in_rd[0]    = 5'(rd_0);
        in_rd_we[0] = 1'(we_0);
        in_rs1[1]   = 5'(rs1_1);
        in_rs2[1]   = 5'(rs2_1);
        in_rd[1]    = 5'(rd_1);
        in_rd_we[1] = 1'(we_1);
        #1;
    endtask

    task automatic idle();
        in_valid = '0;
        in_rs1   = '0;
        in_rs2   = '0;
        in_rd    = '0;
        in_rd_we = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        int bad;
        rst = 1'b1;
        tick();
        tick();
        got = obs_vec();
        checks++;
        if (got !== 54'd0) begin fails++; $display("FAIL reset_outputs: got %h want 0", got); end
        checks++;
        if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        bad = -1;
        for (int i = 0; i < 32; i++) if (dut.rat[i] !== 6'(i)) bad = i;
        checks++;
        if (bad != -1) begin fails++; $display("FAIL reset_rat: entry %0d got %0d want %0d", bad, dut.rat[bad], bad); end
        checks++;
        if (dut.free_count !== 6'd32) begin fails++; $display("FAIL reset_count: got %0d want 32", dut.free_count); end
        checks++;
        if (dut.busy !== 64'd0) begin fails++; $display("FAIL reset_busy: got %h want 0", dut.busy); end
        rst = 1'b0;
    endtask

    task automatic test_basic();
        do_reset();
        set_group(2, 3, 1, 1, 1, 1, 4, 1);
        checks++;
        if (in_ready !== 1'b1) begin fails++; $display("FAIL basic_ready: got %b want 1", in_ready); end
        exp_q.push_back(mk(3, 2, 3, 32, 1, 1, 1, 32, 32, 33, 4, 0, 0));
        tick();
        idle();
        got = obs_vec(); want = exp_q.pop_front();
        checks++;
        if (got !== want) begin fails++; $display("FAIL basic: got %h want %h", got, want); end
    endtask

    task automatic test_same_rd();
        do_reset();
        set_group(6, 7, 5, 1, 8, 9, 5, 1);
        exp_q.push_back(mk(3, 6, 7, 32, 5, 1, 1, 8, 9, 33, 32, 1, 1));
        tick();
        got = obs_vec(); want = exp_q.pop_front();
        checks++;
        if (got !== want) begin fails++; $display("FAIL same_rd: got %h want %h", got, want); end
        set_group(5, 5, 0, 0, 0, 0, 0, 0);
        exp_q.push_back(mk(3, 33, 33, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1));
        tick();
        idle();
        got = obs_vec(); want = exp_q.pop_front();
        checks++;
        if (got !== want) begin fails++; $display("FAIL same_rd_read: got %h want %h", got, want); end
    endtask

    task automatic test_x0();
        do_reset();
        set_group(0, 0, 0, 1, 0, 3, 0, 1);
        exp_q.push_back(mk(3, 0, 0, 0, 0, 1, 1, 0, 3, 0, 0, 1, 1));
        tick();
        idle();
        got = obs_vec(); want = exp_q.pop_front();
        checks++;
        if (got !== want) begin fails++; $display("FAIL x0: got %h want %h", got, want); end
        checks++;
        if (dut.free_count !== 6'd32) begin fails++; $display("FAIL x0_count: got %0d want 32", dut.free_count); end
    endtask

    task automatic test_wb_bypass();
        do_reset();
        set_group(0, 0, 1, 1, 0, 0, 0, 0);
        exp_q.push_back(mk(3, 0, 0, 32, 1, 1, 1, 0, 0, 0, 0, 1, 1));
        tick();
        got = obs_vec(); want = exp_q.pop_front();
        checks++;
        if (got !== want) begin fails++; $display("FAIL wb_alloc: got %h want %h", got, want); end
        checks++;
        if (dut.busy[32] !== 1'b1) begin fails++; $display("FAIL wb_busy_set: got %b want 1", dut.busy[32]); end
        set_group(1, 0, 0, 0, 1, 0, 0, 0);
        exp_q.push_back(mk(3, 32, 0, 0, 0, 0, 1, 32, 0, 0, 0, 0, 1));
        tick();
        got = obs_vec(); want = exp_q.pop_front();
        checks++;
        if (got !== want) begin fails++; $display("FAIL wb_not_ready: got %h want %h", got, want); end
        set_group(1, 1, 0, 0, 0, 1, 0, 0);
        wb_valid      = 2'b01;
        wb_phys_rd[0] = 6'd32;
        exp_q.push_back(mk(3, 32, 32, 0, 0, 1, 1, 0, 32, 0, 0, 1, 1));
        tick();
        wb_valid = '0;
        wb_phys_rd = '0;
        idle();
        got = obs_vec(); want = exp_q.pop_front();
        checks++;
        if (got !== want) begin fails++; $display("FAIL wb_bypass: got %h want %h", got, want); end
        checks++;
        if (dut.busy[32] !== 1'b0) begin fails++; $display("FAIL wb_busy_clear: got %b want 0", dut.busy[32]); end
    endtask

    task automatic test_drain_commit();
        do_reset();
        for (int k = 0; k < 15; k++) begin
            set_group(0, 0, 2 * k + 1, 1, 0, 0, 2 * k + 2, 1);
            exp_q.push_back(mk(3, 0, 0, 32 + 2 * k, 2 * k + 1, 1, 1, 0, 0, 33 + 2 * k, 2 * k + 2, 1, 1));
            tick();
            got = obs_vec(); want = exp_q.pop_front();
            checks++;
            if (got !== want) begin fails++; $display("FAIL drain_%0d: got %h want %h", k, got, want); end
        end
        set_group(0, 0, 31, 1, 0, 0, 0, 0);
        exp_q.push_back(mk(3, 0, 0, 62, 31, 1, 1, 0, 0, 0, 0, 1, 1));
        tick();
        got = obs_vec(); want = exp_q.pop_front();
        checks++;
        if (got !== want) begin fails++; $display("FAIL drain_last: got %h want %h", got, want); end
        set_group(0, 0, 1, 1, 0, 0, 2, 1);
        checks++;
        if (in_ready !== 1'b0) begin fails++; $display("FAIL drain_ready: got %b want 0", in_ready); end
        checks++;
        if (dut.free_count !== 6'd1) begin fails++; $display("FAIL drain_count: got %0d want 1", dut.free_count); end
        tick();
        checks++;
        if (out_valid !== 2'b00) begin fails++; $display("FAIL drain_blocked: got %b want 00", out_valid); end
        idle();
        commit_valid          = 2'b11;
        commit_old_phys_rd[0] = 6'd7;
        commit_old_phys_rd[1] = 6'd9;
        tick();
        commit_valid       = '0;
        commit_old_phys_rd = '0;
        checks++;
        if (in_ready !== 1'b1) begin fails++; $display("FAIL commit_ready: got %b want 1", in_ready); end
        checks++;
        if (dut.free_count !== 6'd3) begin fails++; $display("FAIL commit_count: got %0d want 3", dut.free_count); end
        set_group(0, 0, 1, 1, 0, 0, 0, 0);
        exp_q.push_back(mk(3, 0, 0, 63, 32, 1, 1, 0, 0, 0, 0, 1, 1));
        tick();
        got = obs_vec(); want = exp_q.pop_front();
        checks++;
        if (got !== want) begin fails++; $display("FAIL wrap_63: got %h want %h", got, want); end
        set_group(0, 0, 2, 1, 0, 0, 3, 1);
        exp_q.push_back(mk(3, 0, 0, 7, 33, 1, 1, 0, 0, 9, 34, 1, 1));
        tick();
        idle();
        got = obs_vec(); want = exp_q.pop_front();
        checks++;
        if (got !== want) begin fails++; $display("FAIL wrap_7_9: got %h want %h", got, want); end
        checks++;
        if (dut.free_count !== 6'd0) begin fails++; $display("FAIL wrap_count: got %0d want 0", dut.free_count); end
    endtask

    task automatic test_stall();
        int bad;
        do_reset();
        set_group(2, 3, 1, 1, 1, 1, 4, 1);
        exp_q.push_back(mk(3, 2, 3, 32, 1, 1, 1, 32, 32, 33, 4, 0, 0));
        tick();
        got = obs_vec(); want = exp_q.pop_front();
        checks++;
        if (got !== want) begin fails++; $display("FAIL stall_first: got %h want %h", got, want); end
        held  = want;
        stall = 1'b1;
        set_group(1, 4, 5, 1, 5, 0, 1, 1);
        checks++;
        if (in_ready !== 1'b0) begin fails++; $display("FAIL stall_ready: got %b want 0", in_ready); end
        for (int c = 0; c < 3; c++) begin
            tick();
            got = obs_vec();
            checks++;
            if (got !== held) begin fails++; $display("FAIL stall_hold_%0d: got %h want %h", c, got, held); end
            checks++;
            if (in_ready !== 1'b0) begin fails++; $display("FAIL stall_ready_%0d: got %b want 0", c, in_ready); end
            checks++;
            if (dut.free_count !== 6'd30) begin fails++; $display("FAIL stall_count_%0d: got %0d want 30", c, dut.free_count); end
        end
        stall = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin fails++; $display("FAIL unstall_ready: got %b want 1", in_ready); end
        exp_q.push_back(mk(3, 32, 33, 34, 5, 0, 0, 34, 0, 35, 32, 0, 1));
        tick();
        got = obs_vec(); want = exp_q.pop_front();
        checks++;
        if (got !== want) begin fails++; $display("FAIL unstall_group: got %h want %h", got, want); end
        set_group(0, 0, 2, 1, 0, 0, 0, 0);
        tick();
        stall = 1'b1;
        idle();
        tick();
        checks++;
        if (out_valid !== 2'b11) begin fails++; $display("FAIL stall_held_valid: got %b want 11", out_valid); end
        rst = 1'b1;
        tick();
        rst   = 1'b0;
        stall = 1'b0;
        checks++;
        if (out_valid !== 2'b00) begin fails++; $display("FAIL stall_reset_valid: got %b want 00", out_valid); end
        bad = -1;
        for (int i = 0; i < 32; i++) if (dut.rat[i] !== 6'(i)) bad = i;
        checks++;
        if (bad != -1) begin fails++; $display("FAIL stall_reset_rat: entry %0d got %0d want %0d", bad, dut.rat[bad], bad); end
        checks++;
        if (dut.free_count !== 6'd32) begin fails++; $display("FAIL stall_reset_count: got %0d want 32", dut.free_count); end
    endtask

    initial begin
        rst                = 1'b1;
        stall              = 1'b0;
        wb_valid           = '0;
        wb_phys_rd         = '0;
        commit_valid       = '0;
        commit_old_phys_rd = '0;
        idle();
        test_reset();
        test_basic();
        test_same_rd();
        test_x0();
        test_wb_bypass();
        test_drain_commit();
        test_stall();
        checks++;
        if (exp_q.size() != 0) begin fails++; $display("FAIL scoreboard_drain: got %0d entries want 0", exp_q.size()); end
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/rename_unit.md
Name: rename_unit

Overview:
- 2-wide register rename stage, directly upstream of the issue queue.
- Maps architectural rs1/rs2/rd to physical registers using a rename table (RAT), a circular free list and a busy table.
- Produces registered rename results plus per-source ready bits, which feed the issue queue's dispatch interface.
- Takes physical-register writebacks to clear busy bits, and ROB commits to return stale physical registers to the free list.

Parameters:
- PHYS_REGS, 64, number of physical registers; power of two, must be > 32.
- PHYS_REGS_ADDR_WIDTH, $clog2(PHYS_REGS), physical register index width.
- FREE_LIST_SIZE, PHYS_REGS-32, free-list capacity.
- DISPATCH_WIDTH, 2, lanes per group; fixed at 2.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- in_valid  in  2  per-lane decoded instruction valid.
- in_rs1, in_rs2, in_rd  in  2x5  architectural register indices.
- in_rd_we  in  2  lane writes rd.
- in_ready  out  1  group accepted this cycle when in_ready && |in_valid.
- out_valid  out  2  per-lane rename result valid.
- out_phys_rs1, out_phys_rs2, out_phys_rd, out_old_phys_rd  out  2xPHYS_REGS_ADDR_WIDTH  renamed indices.
- out_rs1_ready, out_rs2_ready  out  2  source value is available.
- stall  in  1  downstream cannot accept (issue queue full).
- wb_valid  in  2  writeback lane valid.
- wb_phys_rd  in  2xPHYS_REGS_ADDR_WIDTH  physical register written back.
- commit_valid  in  2  ROB commit lane valid.
- commit_old_phys_rd  in  2xPHYS_REGS_ADDR_WIDTH  stale register to free.

Behaviour:
- Reset:
  - RAT[i]=i for i in 0..31.
  - Free list holds 32..PHYS_REGS-1 in ascending order; head=0, tail=0, count=FREE_LIST_SIZE.
  - All busy bits 0.
  - out_valid=0; all other outputs 0.
  - Reset mid-operation discards any held output and any in-flight group.
- Allocation need for a lane: in_valid && in_rd_we && in_rd!=0. need_cnt ∈ {0,1,2}.
- in_ready = (free_count >= 2) && !(|out_valid && stall). in_ready is independent of need_cnt.
- Accept (in_ready && |in_valid):
  - Lane 0 allocates before lane 1; pops need_cnt entries from head; head wraps modulo FREE_LIST_SIZE.
  - Sources: x0 always maps to phys 0 with ready=1.
  - Lane-1 rs1/rs2 equal to a lane-0 allocating rd use lane 0's new phys_rd, ready=0.
  - All other sources read the RAT; ready = !busy.
  - Writeback bypass: if a source's phys equals any valid wb_phys_rd this cycle, ready=1.
  - old_phys_rd = RAT[rd] before this group's update. Lane 1 sees lane 0's new mapping if both write the same rd, so old_phys_rd(lane1) = lane 0's new phys.
  - RAT updated at the clock edge; lane 1 wins on identical rd. Allocated phys marked busy.
  - Non-allocating lanes: phys_rd=0, old_phys_rd=0.
- Output register:
  - Results appear the cycle after accept (1-cycle latency).
  - out_valid = registered in_valid.
  - While stall && |out_valid, outputs hold unchanged.
  - If no accept and no stall, out_valid clears to 0.
- Writeback: each valid wb lane clears busy[wb_phys_rd] at the edge. wb to phys 0 is ignored. Clear takes priority over nothing; allocation of the same index in the same cycle is impossible, since busy regs are not on the free list.
- Commit:
  - Each valid commit lane pushes commit_old_phys_rd at tail; lane 0 first. Value 0 is ignored (not pushed).
  - Commit and allocate in the same cycle are both permitted: count += pushes − pops.
  - A pushed entry is not allocatable until the next cycle.
  - Pushing beyond FREE_LIST_SIZE cannot occur legally; an assertion flags it.
- No flush/recovery port; branch recovery is out of scope for this revision.

Test Plan:
- Reset, then accept lanes {add x1,x2,x3; add x4,x1,x1} -> next cycle lane0 phys_rd=32, old=1, rs1=2, rs2=3, both ready=1; lane1 phys_rd=33, rs1=rs2=32, both ready=0.
- Both lanes write x5 -> lane0 phys_rd=32 old=5; lane1 phys_rd=33 old=32; following read of x5 maps to 33.
- Source x0 and rd=x0 -> phys_rs=0 ready=1; no pop; free_count unchanged at 32.
- Drain free list to count=1 with no commits -> in_ready=0. Commit old phys 7 and 9 -> in_ready=1 next cycle, then later allocations return 7 then 9 after wrap.
- wb_phys_rd=32 in the same cycle as a group reading the register mapped to 32 -> ready=1. One cycle later busy[32]=0.
- Assert stall with out_valid=1 for 3 cycles -> outputs held identical, in_ready=0, free list unchanged. Deassert -> next group accepted. Assert rst mid-stall -> out_valid=0, RAT identity.
